// File: rtl/gpu_prim_pkg.sv
// Primitive-pipeline types and packing constants shared by the clip
// sequencer, the clipper wrapper and rasterizer setup.
package gpu_prim_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        RELEASE,
        EMIT
    } clip_seq_state_t;

    localparam int unsigned COMP_W = 24;
    localparam int unsigned VERT_W = 4 * COMP_W;
    localparam int unsigned TRI_W  = 3 * VERT_W;

    localparam int unsigned X_OFF = 0;
    localparam int unsigned Y_OFF = 1;
    localparam int unsigned Z_OFF = 2;
    localparam int unsigned W_OFF = 3;

endpackage

// File: rtl/clip_tri_sequencer.sv
// Feeds one triangle at a time to the clipper, buffers its 0/1/2-triangle
// result and streams the survivors downstream; fully culled input is counted.
module clip_tri_sequencer
    import gpu_prim_pkg::*;
#(
    parameter int unsigned WIDTH = 24
) (
    input  logic                    clk_i,
    input  logic                    reset_n,
    input  logic                    tri_valid_i,
    output logic                    tri_ready_o,
    input  logic [12*WIDTH-1:0]     tri_data_i,
    output logic [12*WIDTH-1:0]     clip_tri_o,
    output logic                    clip_start_o,
    input  logic                    clip_done_i,
    input  logic                    clip_valid_i,
    input  logic [1:0]              clip_num_tri_i,
    input  logic [24*WIDTH-1:0]     clip_verts_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [12*WIDTH-1:0]     out_tri_o,
    output logic                    out_last_o,
    output logic [15:0]             culled_cnt_o
);

    localparam int unsigned TW = 12 * WIDTH;

    clip_seq_state_t state, next_state;

    logic            buf_valid;
    logic [1:0]      buf_num;
    logic [2*TW-1:0] buf_verts;
    logic            idx;

    logic            culled;
    logic            handshake;
    logic            start_d;
    logic            load_buf;
    logic            cnt_inc;
    logic            emit_load;
    logic            idx_d;
    logic [1:0]      num_eff;

    assign tri_ready_o = (state == IDLE);
    assign culled      = !buf_valid || (buf_num == 2'd0);
    assign handshake   = out_valid_o && out_ready_i;
    // A clipper count of 3 is not meaningful here; cap at the 2-entry buffer.
    assign num_eff     = (buf_num == 2'd3) ? 2'd2 : buf_num;

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (tri_valid_i) next_state = START;
            START:   if (clip_done_i) next_state = RELEASE;
            RELEASE: if (!clip_done_i) next_state = culled ? IDLE : EMIT;
            EMIT:    if (handshake && out_last_o) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        start_d   = 1'b0;
        load_buf  = 1'b0;
        cnt_inc   = 1'b0;
        emit_load = 1'b0;
        idx_d     = idx;
        unique case (state)
            IDLE:  start_d = tri_valid_i;
            START: begin
                start_d  = !clip_done_i;
                load_buf = clip_done_i;
            end
            RELEASE: if (!clip_done_i) begin
                cnt_inc   = culled;
                emit_load = !culled;
                idx_d     = 1'b0;
            end
            EMIT: if (handshake && !out_last_o) begin
                emit_load = 1'b1;
                idx_d     = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            clip_tri_o   <= '0;
            clip_start_o <= 1'b0;
            buf_valid    <= 1'b0;
            buf_num      <= '0;
            buf_verts    <= '0;
            idx          <= 1'b0;
            out_valid_o  <= 1'b0;
            out_tri_o    <= '0;
            out_last_o   <= 1'b0;
            culled_cnt_o <= '0;
        end else begin
            clip_start_o <= start_d;
            out_valid_o  <= (next_state == EMIT);
            idx          <= idx_d;
            if (state == IDLE && tri_valid_i) clip_tri_o <= tri_data_i;
            if (load_buf) begin
                buf_valid <= clip_valid_i;
                buf_num   <= clip_num_tri_i;
                buf_verts <= clip_verts_i;
            end
            if (emit_load) begin
                out_tri_o  <= idx_d ? buf_verts[TW +: TW] : buf_verts[0 +: TW];
                out_last_o <= ({1'b0, idx_d} + 2'd1) == num_eff;
            end
            if (cnt_inc && culled_cnt_o != '1) culled_cnt_o <= culled_cnt_o + 16'd1;
        end
    end

endmodule

// File: tb/tb_clip_tri_sequencer.sv
// Directed bench for clip_tri_sequencer: behavioural clipper, scoreboard of
// expected downstream beats, immediate assertions at every comparison.
module tb_clip_tri_sequencer;

    localparam int unsigned WIDTH = 24;
    localparam int unsigned TW    = 12 * WIDTH;

    logic              clk_i = 1'b0;
    logic              reset_n = 1'b0;
    logic              tri_valid_i = 1'b0;
    logic              tri_ready_o;
    logic [TW-1:0]     tri_data_i = '0;
    logic [TW-1:0]     clip_tri_o;
    logic              clip_start_o;
    logic              clip_done_i = 1'b0;
    logic              clip_valid_i = 1'b0;
    logic [1:0]        clip_num_tri_i = '0;
    logic [2*TW-1:0]   clip_verts_i = '0;
    logic              out_valid_o;
    logic              out_ready_i = 1'b1;
    logic [TW-1:0]     out_tri_o;
    logic              out_last_o;
    logic [15:0]       culled_cnt_o;

    clip_tri_sequencer #(.WIDTH(WIDTH)) dut (
        .clk_i          (clk_i),
        .reset_n        (reset_n),
        .tri_valid_i    (tri_valid_i),
        .tri_ready_o    (tri_ready_o),
        .tri_data_i     (tri_data_i),
        .clip_tri_o     (clip_tri_o),
        .clip_start_o   (clip_start_o),
        .clip_done_i    (clip_done_i),
        .clip_valid_i   (clip_valid_i),
        .clip_num_tri_i (clip_num_tri_i),
        .clip_verts_i   (clip_verts_i),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .out_tri_o      (out_tri_o),
        .out_last_o     (out_last_o),
        .culled_cnt_o   (culled_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;
    int hs_cnt   = 0;

    // Clipper model configuration, set by the stimulus before each triangle.
    int unsigned       cfg_delay = 3;
    int unsigned       cfg_hold  = 0;
    logic              cfg_valid = 1'b1;
    logic [1:0]        cfg_num   = 2'd1;
    logic [2*TW-1:0]   cfg_verts = '0;

    typedef struct packed {
        logic [TW-1:0] tri_v;
        logic          last;
    } beat_t;
    beat_t sb[$];

    task automatic chk(input string tag, input logic [2*TW-1:0] obs, input logic [2*TW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2*TW-1:0] mk_verts(input logic [WIDTH-1:0] base);
        logic [2*TW-1:0] v;
        v = '0;
        for (int k = 0; k < 6; k++)
            for (int c = 0; c < 4; c++)
                v[k*4*WIDTH + c*WIDTH +: WIDTH] = base + WIDTH'(k*4 + c);
        return v;
    endfunction

    // Behavioural clipper: done cfg_delay cycles after start, held cfg_hold
    // cycles past the start drop.
    always begin
        @(posedge clk_i); #1;
        if (reset_n && clip_start_o && !clip_done_i) begin
            for (int unsigned i = 1; i < cfg_delay; i++) begin
                @(posedge clk_i); #1;
                chk("start_held", 576'(clip_start_o), 576'(1));
            end
            @(posedge clk_i); #1;
            clip_done_i    = 1'b1;
            clip_valid_i   = cfg_valid;
            clip_num_tri_i = cfg_num;
            clip_verts_i   = cfg_verts;
            @(posedge clk_i); #1;
            chk("start_dropped", 576'(clip_start_o), 576'(0));
            for (int unsigned i = 0; i < cfg_hold; i++) begin
                @(posedge clk_i); #1;
                chk("no_restart_in_done", 576'(clip_start_o), 576'(0));
                chk("no_emit_in_done", 576'(out_valid_o), 576'(0));
            end
            clip_done_i = 1'b0;
        end
    end

    // Output monitor: pops the scoreboard on each handshake, checks hold
    // stability under backpressure and readiness after the final beat.
    logic          prev_stall = 1'b0;
    logic [TW-1:0] prev_tri;
    logic          prev_last;
    logic          ready_next = 1'b0;
    always @(negedge clk_i) begin
        if (!reset_n) begin
            prev_stall = 1'b0;
            ready_next = 1'b0;
        end else begin
            beat_t b;
            if (ready_next) chk("ready_after_last", 576'(tri_ready_o), 576'(1));
            ready_next = 1'b0;
            if (prev_stall) begin
                chk("stall_valid", 576'(out_valid_o), 576'(1));
                chk("stall_tri", 576'(out_tri_o), 576'(prev_tri));
                chk("stall_last", 576'(out_last_o), 576'(prev_last));
            end
            if (out_valid_o) chk("emit_after_done_low", 576'(clip_done_i), 576'(0));
            if (out_valid_o && out_ready_i) begin
                hs_cnt++;
                chk("beat_expected", 576'(sb.size() != 0), 576'(1));
                if (sb.size() != 0) begin
                    b = sb.pop_front();
                    chk("beat_tri", 576'(out_tri_o), 576'(b.tri_v));
                    chk("beat_last", 576'(out_last_o), 576'(b.last));
                end
                if (out_last_o) ready_next = 1'b1;
            end
            prev_stall = out_valid_o && !out_ready_i;
            prev_tri   = out_tri_o;
            prev_last  = out_last_o;
        end
    end

    int exp_culled = 0;

    task automatic send_tri(input logic [TW-1:0] data);
        int n;
        n = 0;
        while (!tri_ready_o && n < 100) begin
            @(negedge clk_i); n++;
        end
        chk("accept_ready", 576'(tri_ready_o), 576'(1));
        if (cfg_valid && cfg_num != 2'd0) begin
            sb.push_back('{tri_v: cfg_verts[0 +: TW], last: (cfg_num == 2'd1)});
            if (cfg_num != 2'd1) sb.push_back('{tri_v: cfg_verts[TW +: TW], last: 1'b1});
        end else begin
            exp_culled = (exp_culled == 16'hFFFF) ? exp_culled : exp_culled + 1;
        end
        @(negedge clk_i);
        tri_data_i  = data;
        tri_valid_i = 1'b1;
        @(posedge clk_i); #1;
        tri_valid_i = 1'b0;
        chk("clip_tri", 576'(clip_tri_o), 576'(data));
        chk("busy_after_accept", 576'(tri_ready_o), 576'(0));
        chk("start_rise", 576'(clip_start_o), 576'(1));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk_i);
        while (!(tri_ready_o && !out_valid_o) && n < 200) begin
            @(negedge clk_i); n++;
        end
        chk("idle_timeout", 576'(n < 200), 576'(1));
        repeat (2) @(negedge clk_i);
        chk("sb_drained", 576'(sb.size()), 576'(0));
    endtask

    initial begin
        repeat (3) @(negedge clk_i);
        reset_n = 1'b1;
        repeat (2) @(negedge clk_i);
        chk("rst_ready", 576'(tri_ready_o), 576'(1));
        chk("rst_start", 576'(clip_start_o), 576'(0));
        chk("rst_valid", 576'(out_valid_o), 576'(0));
        chk("rst_culled", 576'(culled_cnt_o), 576'(0));
        chk("rst_clip_tri", 576'(clip_tri_o), 576'(0));

        // Single surviving triangle.
        cfg_delay = 3; cfg_valid = 1'b1; cfg_num = 2'd1; cfg_verts = mk_verts(24'h001000);
        send_tri({12{24'h00A001}});
        wait_idle();

        // Two triangles, first beat backpressured for 3 cycles.
        hs_cnt = 0;
        cfg_num = 2'd2; cfg_verts = mk_verts(24'h002000);
        out_ready_i = 1'b0;
        send_tri({12{24'h00A002}});
        for (int n = 0; n < 100 && !out_valid_o; n++) @(negedge clk_i);
        chk("first_beat_last", 576'(out_last_o), 576'(0));
        repeat (3) @(negedge clk_i);
        out_ready_i = 1'b1;
        wait_idle();
        chk("two_handshakes", 576'(hs_cnt), 576'(2));

        // Culled results: invalid, valid with zero count, invalid with count.
        hs_cnt = 0;
        cfg_valid = 1'b0; cfg_num = 2'd0;
        send_tri({12{24'h00A003}});
        wait_idle();
        chk("culled_1", 576'(culled_cnt_o), 576'(exp_culled));
        cfg_valid = 1'b1; cfg_num = 2'd0;
        send_tri({12{24'h00A004}});
        wait_idle();
        cfg_valid = 1'b0; cfg_num = 2'd2;
        send_tri({12{24'h00A005}});
        wait_idle();
        chk("culled_3", 576'(culled_cnt_o), 576'(exp_culled));
        chk("culled_no_beats", 576'(hs_cnt), 576'(0));

        // Clipper holds done 4 cycles past start drop, 1-cycle done latency.
        cfg_valid = 1'b1; cfg_num = 2'd1; cfg_delay = 1; cfg_hold = 4;
        cfg_verts = mk_verts(24'h003000);
        send_tri({12{24'h00A006}});
        wait_idle();
        cfg_hold = 0; cfg_delay = 3;

        // Count of 3 behaves as 2.
        hs_cnt = 0;
        cfg_num = 2'd3; cfg_verts = mk_verts(24'h004000);
        send_tri({12{24'h00A007}});
        wait_idle();
        chk("num3_handshakes", 576'(hs_cnt), 576'(2));

        // Reset while the first of two beats is pending.
        hs_cnt = 0;
        cfg_num = 2'd2; cfg_verts = mk_verts(24'h005000);
        out_ready_i = 1'b0;
        send_tri({12{24'h00A008}});
        for (int n = 0; n < 100 && !out_valid_o; n++) @(negedge clk_i);
        chk("pre_reset_valid", 576'(out_valid_o), 576'(1));
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_valid", 576'(out_valid_o), 576'(0));
        chk("async_rst_start", 576'(clip_start_o), 576'(0));
        chk("async_rst_culled", 576'(culled_cnt_o), 576'(0));
        sb.delete();
        exp_culled = 0;
        repeat (2) @(negedge clk_i);
        reset_n = 1'b1;
        out_ready_i = 1'b1;
        repeat (6) @(negedge clk_i);
        chk("post_rst_ready", 576'(tri_ready_o), 576'(1));
        chk("post_rst_no_beat", 576'(hs_cnt), 576'(0));

        // Saturation of the cull counter.
        @(negedge clk_i);
        force dut.culled_cnt_o = 16'hFFFF;
        #1;
        release dut.culled_cnt_o;
        exp_culled = 16'hFFFF;
        @(negedge clk_i);
        chk("preload_culled", 576'(culled_cnt_o), 576'(16'hFFFF));
        cfg_valid = 1'b0; cfg_num = 2'd0;
        send_tri({12{24'h00A009}});
        wait_idle();
        chk("culled_saturate", 576'(culled_cnt_o), 576'(exp_culled));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL global_timeout observed=running expected=finished");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "timeout");
    end

endmodule
